mmio_uart_tx: RTL and testbench
===============================

// Module: mmio_uart_tx
// PURPOSE
//  Memory-mapped 8N1 UART transmitter on the MEM stage's store path, driven by the same wren/ADDR/DIN as DRAM.
//  A store to TX_ADDR queues one byte in a small FIFO; a status address reports busy/full/overflow.
//  Serialises each byte on `tx`. The core's character console becomes a real serial output.
//  Never stalls the pipeline: the MEM stage has no back-pressure, so the block drops bytes into a full FIFO and flags them.
// PARAMETERS
//  CLKS_PER_BIT  16     clock cycles per serial bit (>=2)
//  FIFO_DEPTH    4      byte FIFO entries (power of two, >=2)
//  TX_ADDR       8'hFF  word address; a store pushes wdata[7:0]
//  STATUS_ADDR   8'hFE  word address; read status, write-1 to bit1 clears overflow
// PORTS
//  clock       in   1   rising-edge clock
//  clear       in   1   synchronous reset, active-high
//  wren        in   1   store strobe (MEM_signals[6])
//  addr        in   8   word address (MEM_aluResult[7:0])
//  wdata       in   32  store data (MEM_dataB)
//  rdata       out  32  status word {29'b0, overflow, full, busy}, combinational
//  tx          out  1   serial line, idle high, registered
//  busy        out  1   state!=IDLE or FIFO not empty
//  fifo_count  out  $clog2(FIFO_DEPTH)+1  bytes queued
//  overflow    out  1   sticky: a push was dropped
// BEHAVIOUR
//  Reset (clear=1 at an edge):
//   - state=IDLE, tx=1, FIFO empty (count=0, pointers 0), overflow=0, bit/baud counters 0.
//   - Reset mid-frame aborts the frame: tx=1 after that edge and all queued bytes are discarded.
//   - clear has priority over every other input.
//  Push: edge with wren && addr==TX_ADDR.
//   - Not full: store wdata[7:0]; count+1 visible after the edge. wdata[31:8] is ignored.
//   - Full and no pop on the same edge: byte dropped, overflow<=1.
//   - Full with a pop on the same edge: push accepted, count unchanged.
//  Status write: wren && addr==STATUS_ADDR && wdata[1] -> overflow<=0.
//   - A drop on the same edge wins; overflow stays 1.
//   - Other addresses are ignored. The block never drives DRAM.
//  Pop: occurs only on an edge where the FSM loads a byte (see below). Read pointer wraps modulo FIFO_DEPTH.
//  FSM, one state transition per edge; baud counter counts 0..CLKS_PER_BIT-1:
//   - IDLE: tx=1. If count!=0: pop into shift reg, tx<=0, baud<=0 -> START.
//   - START: after CLKS_PER_BIT cycles, tx<=shift[0], bit<=0 -> DATA.
//   - DATA: each bit held CLKS_PER_BIT cycles, LSB first. After bit 7's period, tx<=1 -> STOP.
//   - STOP: hold tx=1 for CLKS_PER_BIT cycles, then:
//     - count!=0: pop, tx<=0 -> START. Back-to-back frames have no idle gap.
//     - otherwise -> IDLE.
//  Timing:
//   - Write at edge E0 -> tx falls at E1 if the FSM was IDLE.
//   - Frame length is exactly 10*CLKS_PER_BIT cycles.
//   - busy=1 from after E0 until the edge the FSM returns to IDLE with the FIFO empty.
//  Widths:
//   - fifo_count ranges 0..FIFO_DEPTH.
//   - full = (fifo_count==FIFO_DEPTH).
//   - Pointers are $clog2(FIFO_DEPTH) bits and wrap naturally.
// TESTING (CLKS_PER_BIT=4, FIFO_DEPTH=4)
//  1. Reset, then store 0x41 to 0xFF -> tx low at next edge. Sampled mid-bit, tx yields 0,1,0,0,0,0,0,1,0,1.
//     Frame is 40 cycles; busy drops after the stop bit.
//  2. Store 0x48 then 0x69 on consecutive cycles -> two frames back-to-back, no idle cycle between the stop bit and the next start.
//  3. Six stores on consecutive cycles while IDLE -> the first pops immediately and the next four fill the FIFO (count=4).
//     The sixth is dropped: overflow=1, rdata=0x7. Exactly five frames follow.
//  4. With overflow=1, write 0x2 to 0xFE -> overflow=0, rdata[2]=0. Write 0x0 to 0xFE -> no change.
//  5. Assert clear during DATA bit 3 with 2 bytes queued -> after the edge tx=1, count=0, busy=0, no further frames.
//  6. While FIFO full, push on the STOP->START pop edge -> push accepted, count stays 4, overflow stays 0.

Source files
------------

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter sitting on the MEM-stage store path.
// Stores to TX_ADDR queue a byte in a small FIFO. The FSM drains the FIFO onto
// the tx line. The pipeline never stalls: pushes into a full FIFO are dropped
// and recorded in a sticky overflow flag.
module mmio_uart_tx #(
  parameter int         CLKS_PER_BIT = 16,
  parameter int         FIFO_DEPTH   = 4,
  parameter logic [7:0] TX_ADDR      = 8'hFF,
  parameter logic [7:0] STATUS_ADDR  = 8'hFE
) (
  input  logic                          clock,
  input  logic                          clear,
  input  logic                          wren,
  input  logic [7:0]                    addr,
  input  logic [31:0]                   wdata,
  output logic [31:0]                   rdata,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} txState_t;

  txState_t          state;
  txState_t          nextState;
  logic [BW-1:0]     baudCnt;
  logic [BW-1:0]     nextBaud;
  logic [2:0]        bitCnt;
  logic [2:0]        nextBit;
  logic [7:0]        shiftReg;
  logic [7:0]        nextShift;
  logic              nextTx;
  logic              pop;

  logic [7:0]        fifoMem [FIFO_DEPTH];
  logic [PW-1:0]     wrPtr;
  logic [PW-1:0]     rdPtr;
  logic [CW-1:0]     nextCount;
  logic              nextOverflow;

  logic              pushReq;
  logic              statusClr;
  logic              fifoFull;
  logic              fifoEmpty;
  logic              pushAccept;
  logic              pushDrop;
  logic              baudDone;
  logic              unusedBits;

  assign pushReq    = wren && (addr == TX_ADDR);
  assign statusClr  = wren && (addr == STATUS_ADDR) && wdata[1];
  assign fifoFull   = (fifo_count == CW'(FIFO_DEPTH));
  assign fifoEmpty  = (fifo_count == {CW{1'b0}});
  // A full FIFO still takes the byte when the FSM frees a slot on the same edge.
  assign pushAccept = pushReq && (!fifoFull || pop);
  assign pushDrop   = pushReq && fifoFull && !pop;
  assign baudDone   = (baudCnt == BW'(CLKS_PER_BIT - 1));
  assign busy       = (state != IDLE) || !fifoEmpty;
  assign rdata      = {29'd0, overflow, fifoFull, busy};
  assign unusedBits = ^wdata[31:8];

  // Next-state, next-line-level and FIFO pop decision for the serialiser.
  always_comb begin
    nextState = state;
    nextBaud  = baudCnt;
    nextBit   = bitCnt;
    nextShift = shiftReg;
    nextTx    = tx;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        nextTx = 1'b1;
        if (!fifoEmpty) begin
          pop       = 1'b1;
          nextShift = fifoMem[rdPtr];
          nextTx    = 1'b0;
          nextBaud  = {BW{1'b0}};
          nextState = START;
        end else begin
          nextBaud  = {BW{1'b0}};
        end
      end
      START: begin
        if (baudDone) begin
          nextTx    = shiftReg[0];
          nextBit   = 3'd0;
          nextBaud  = {BW{1'b0}};
          nextState = DATA;
        end else begin
          nextBaud  = baudCnt + BW'(1);
        end
      end
      DATA: begin
        if (baudDone) begin
          nextBaud = {BW{1'b0}};
          if (bitCnt == 3'd7) begin
            nextTx    = 1'b1;
            nextState = STOP;
          end else begin
            nextShift = {1'b0, shiftReg[7:1]};
            nextTx    = shiftReg[1];
            nextBit   = bitCnt + 3'd1;
          end
        end else begin
          nextBaud = baudCnt + BW'(1);
        end
      end
      STOP: begin
        if (baudDone) begin
          nextBaud = {BW{1'b0}};
          // Chain straight into the next start bit so frames have no idle gap.
          if (!fifoEmpty) begin
            pop       = 1'b1;
            nextShift = fifoMem[rdPtr];
            nextTx    = 1'b0;
            nextState = START;
          end else begin
            nextTx    = 1'b1;
            nextState = IDLE;
          end
        end else begin
          nextBaud = baudCnt + BW'(1);
        end
      end
      default: begin
        nextTx    = 1'b1;
        nextBaud  = {BW{1'b0}};
        nextState = IDLE;
      end
    endcase
  end

  // FIFO occupancy and sticky overflow; a drop beats a same-edge clear request.
  always_comb begin
    nextCount = fifo_count;
    case ({pushAccept, pop})
      2'b10:   nextCount = fifo_count + CW'(1);
      2'b01:   nextCount = fifo_count - CW'(1);
      default: nextCount = fifo_count;
    endcase
    if (pushDrop) begin
      nextOverflow = 1'b1;
    end else if (statusClr) begin
      nextOverflow = 1'b0;
    end else begin
      nextOverflow = overflow;
    end
  end

  // Control registers: FSM, counters, line driver, FIFO pointers and flags.
  always_ff @(posedge clock) begin
    if (clear) begin
      state      <= IDLE;
      baudCnt    <= {BW{1'b0}};
      bitCnt     <= 3'd0;
      shiftReg   <= 8'd0;
      tx         <= 1'b1;
      wrPtr      <= {PW{1'b0}};
      rdPtr      <= {PW{1'b0}};
      fifo_count <= {CW{1'b0}};
      overflow   <= 1'b0;
    end else begin
      state      <= nextState;
      baudCnt    <= nextBaud;
      bitCnt     <= nextBit;
      shiftReg   <= nextShift;
      tx         <= nextTx;
      fifo_count <= nextCount;
      overflow   <= nextOverflow;
      if (pushAccept) wrPtr <= wrPtr + PW'(1);
      if (pop)        rdPtr <= rdPtr + PW'(1);
    end
  end

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clock) begin
    if (pushAccept && !clear) begin
      fifoMem[wrPtr] <= wdata[7:0];
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx (CLKS_PER_BIT=4, FIFO_DEPTH=4). Stored
// bytes are pushed to a scoreboard queue; a line monitor decodes every frame
// on tx at mid-bit and pops/compares against the scoreboard.
module tb_mmio_uart_tx;

  logic        clk;
  logic        clear;
  logic        wren;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        tx;
  logic        busy;
  logic [2:0]  fifo_count;
  logic        overflow;

  int          passCnt  = 0;
  int          checkCnt = 0;
  int          frameCnt = 0;
  int          cyc      = 0;
  logic [7:0]  expQ[$];
  int          startQ[$];
  logic        monActive = 1'b0;
  int          monCnt    = 0;
  logic [9:0]  monBits;

  mmio_uart_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4), .TX_ADDR(8'hFF), .STATUS_ADDR(8'hFE)) dut (
    .clock(clk), .clear(clear), .wren(wren), .addr(addr), .wdata(wdata),
    .rdata(rdata), .tx(tx), .busy(busy), .fifo_count(fifo_count), .overflow(overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCnt = checkCnt + 1;
    assert (obs === exp) passCnt = passCnt + 1;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Line monitor: detect the start bit, sample each bit mid-period, score the frame.
  initial forever begin
    @(negedge clk);
    if (clear === 1'b1) begin
      monActive = 1'b0;
    end else if (!monActive) begin
      if (tx === 1'b0) begin
        monActive = 1'b1;
        monCnt    = 0;
        startQ.push_back(cyc);
      end
    end else begin
      monCnt = monCnt + 1;
      if (((monCnt - 1) % 4) == 0) begin
        monBits[(monCnt - 1) / 4] = tx;
        if (monCnt == 37) begin
          monActive = 1'b0;
          frameCnt  = frameCnt + 1;
          check("start_bit", {31'd0, monBits[0]}, 32'd0);
          check("stop_bit", {31'd0, monBits[9]}, 32'd1);
          check("sb_nonempty", {31'd0, expQ.size() > 0}, 32'd1);
          if (expQ.size() > 0) begin
            check("frame_byte", {24'd0, monBits[8:1]}, {24'd0, expQ.pop_front()});
          end
        end
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // One store cycle; called 1 time unit after a rising edge.
  task automatic store(input logic [7:0] a, input logic [31:0] d, input logic acc);
    wren  = 1'b1;
    addr  = a;
    wdata = d;
    if (a == 8'hFF && acc) expQ.push_back(d[7:0]);
    @(posedge clk);
    #1;
    wren  = 1'b0;
  endtask

  task automatic waitIdle(input int budget, input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n = n + 1;
    end
    check(tag, {31'd0, n < budget}, 32'd1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int f0;
    int txLow;
    clear = 1'b1;
    wren  = 1'b0;
    addr  = 8'd0;
    wdata = 32'd0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_count", {29'd0, fifo_count}, 32'd0);
    check("rst_ovf", {31'd0, overflow}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    sync();
    clear = 1'b0;

    // 1. Single byte 0x41: start latency, frame length, busy drop
    sync();
    f0 = frameCnt;
    store(8'hFF, 32'hDEAD_BE41, 1'b1);
    @(negedge clk);
    check("t1_count_after_push", {29'd0, fifo_count}, 32'd1);
    check("t1_busy_after_push", {31'd0, busy}, 32'd1);
    check("t1_tx_before_start", {31'd0, tx}, 32'd1);
    @(negedge clk);
    check("t1_tx_start", {31'd0, tx}, 32'd0);
    check("t1_count_after_pop", {29'd0, fifo_count}, 32'd0);
    repeat (39) @(negedge clk);
    check("t1_busy_last_cycle", {31'd0, busy}, 32'd1);
    check("t1_tx_stop", {31'd0, tx}, 32'd1);
    @(negedge clk);
    check("t1_busy_done", {31'd0, busy}, 32'd0);
    check("t1_rdata_idle", rdata, 32'd0);
    check("t1_frames", frameCnt - f0, 32'd1);

    // 2. Back-to-back frames with no idle gap
    sync();
    f0 = frameCnt;
    startQ.delete();
    store(8'hFF, 32'h48, 1'b1);
    store(8'hFF, 32'h69, 1'b1);
    waitIdle(200, "t2_idle_timeout");
    check("t2_frames", frameCnt - f0, 32'd2);
    check("t2_starts", startQ.size(), 32'd2);
    if (startQ.size() == 2) check("t2_gap", startQ[1] - startQ[0], 32'd40);

    // 3. Six stores: one pops, four fill, sixth dropped
    sync();
    f0 = frameCnt;
    for (int i = 0; i < 5; i++) store(8'hFF, 32'h10 + i, 1'b1);
    store(8'hFF, 32'h15, 1'b0);
    @(negedge clk);
    check("t3_count_full", {29'd0, fifo_count}, 32'd4);
    check("t3_ovf", {31'd0, overflow}, 32'd1);
    check("t3_rdata", rdata, 32'h7);
    waitIdle(400, "t3_idle_timeout");
    check("t3_frames", frameCnt - f0, 32'd5);
    check("t3_sb_drained", expQ.size(), 32'd0);
    check("t3_rdata_after", rdata, 32'h4);

    // 4. Overflow clear via status write
    sync();
    store(8'hFE, 32'h0, 1'b0);
    @(negedge clk);
    check("t4_zero_write_keeps", {31'd0, overflow}, 32'd1);
    sync();
    store(8'hFD, 32'h2, 1'b0);
    @(negedge clk);
    check("t4_other_addr_keeps", {31'd0, overflow}, 32'd1);
    sync();
    store(8'hFE, 32'h2, 1'b0);
    @(negedge clk);
    check("t4_cleared", {31'd0, overflow}, 32'd0);
    check("t4_rdata2", {31'd0, rdata[2]}, 32'd0);
    sync();
    store(8'hFE, 32'h0, 1'b0);
    @(negedge clk);
    check("t4_zero_write_nochange", {31'd0, overflow}, 32'd0);
    check("t4_no_push", {29'd0, fifo_count}, 32'd0);

    // 5. Clear during DATA bit 3 with two bytes queued
    sync();
    f0 = frameCnt;
    store(8'hFF, 32'hA5, 1'b0);
    store(8'hFF, 32'h5A, 1'b0);
    store(8'hFF, 32'hC3, 1'b0);
    @(negedge clk);
    check("t5_count_queued", {29'd0, fifo_count}, 32'd2);
    repeat (15) @(posedge clk);
    #1;
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    @(negedge clk);
    check("t5_tx_after_clear", {31'd0, tx}, 32'd1);
    check("t5_count_after_clear", {29'd0, fifo_count}, 32'd0);
    check("t5_busy_after_clear", {31'd0, busy}, 32'd0);
    txLow = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1) txLow = txLow + 1;
    end
    check("t5_line_quiet", txLow, 32'd0);
    check("t5_no_frames", frameCnt - f0, 32'd0);

    // 6. Push into full FIFO on the STOP->START pop edge
    sync();
    f0 = frameCnt;
    for (int i = 0; i < 5; i++) store(8'hFF, 32'h30 + i, 1'b1);
    @(negedge clk);
    check("t6_count_full", {29'd0, fifo_count}, 32'd4);
    repeat (36) @(posedge clk);
    #1;
    store(8'hFF, 32'h3F, 1'b1);
    @(negedge clk);
    check("t6_count_stays", {29'd0, fifo_count}, 32'd4);
    check("t6_ovf_clear", {31'd0, overflow}, 32'd0);
    check("t6_next_start", {31'd0, tx}, 32'd0);
    waitIdle(400, "t6_idle_timeout");
    check("t6_frames", frameCnt - f0, 32'd6);
    check("t6_sb_drained", expQ.size(), 32'd0);

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
